// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decode, hazard detection and ID/EX, EX/MEM, MEM/WB control registers for a 5-stage RISC-V pipeline
module ctrl_pipe #(
  parameter bit EN_M       = 1'b0,
  parameter bit EN_FULL_BR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        id_valid,
  input  logic        flush_id,
  input  logic        stall_ext,
  output logic        hazard_stall,
  output logic        ex_alusrc,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_regwrite,
  output logic        ex_memtoreg,
  output logic [1:0]  ex_aluop,
  output logic        ex_br,
  output logic [2:0]  ex_br_f3,
  output logic        ex_jal,
  output logic        ex_jalr,
  output logic        ex_lui,
  output logic        ex_auipc,
  output logic        ex_mul,
  output logic        ex_illegal,
  output logic [4:0]  ex_rd,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic        mem_regwrite,
  output logic        mem_memtoreg,
  output logic [4:0]  mem_rd,
  output logic        wb_regwrite,
  output logic        wb_memtoreg,
  output logic [4:0]  wb_rd
);
  typedef struct packed {
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic [1:0] aluop;
    logic       br;
    logic [2:0] br_f3;
    logic       jal;
    logic       jalr;
    logic       lui;
    logic       auipc;
    logic       mul;
    logic       illegal;
    logic [4:0] rd;
  } ctrl_t;
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] rd;
  } mem_t;
  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] rd;
  } wb_t;
  ctrl_t dec, ex_q;
  mem_t mem_q;
  wb_t wb_q;
  logic use_rs1, use_rs2, bad;
  logic [6:0] op, f7;
  logic [4:0] rs1, rs2, rd_f;
  logic [2:0] f3;
  assign op   = instr[6:0];
  assign rd_f = instr[11:7];
  assign f3   = instr[14:12];
  assign rs1  = instr[19:15];
  assign rs2  = instr[24:20];
  assign f7   = instr[31:25];
  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    bad     = 1'b0;
    case (op)
      7'b0110011: begin
        dec.regwrite = 1'b1;
        dec.aluop    = 2'b10;
        dec.mul      = f7 == 7'b0000001;
        bad          = dec.mul && !EN_M;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      7'b0010011: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = 2'b10;
        use_rs1      = 1'b1;
      end
      7'b0000011: begin
        dec.alusrc   = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        use_rs1      = 1'b1;
      end
      7'b0100011: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      7'b1100011: begin
        dec.aluop = 2'b01;
        dec.br    = 1'b1;
        dec.br_f3 = f3;
        bad       = (f3[2:1] == 2'b01) || (f3[2] && !EN_FULL_BR);
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      7'b1101111: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.jal      = 1'b1;
      end
      7'b1100111: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.jalr     = 1'b1;
        use_rs1      = 1'b1;
      end
      7'b0110111: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.lui      = 1'b1;
      end
      7'b0010111: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.auipc    = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    dec.regwrite = dec.regwrite && (rd_f != 5'd0);
    dec.rd       = dec.regwrite ? rd_f : 5'd0;
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
    end
  end
  assign hazard_stall = id_valid && ex_q.memread && (ex_q.rd != 5'd0) &&
                        ((use_rs1 && rs1 == ex_q.rd) || (use_rs2 && rs2 == ex_q.rd));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!stall_ext) begin
      ex_q  <= (id_valid && !flush_id && !hazard_stall) ? dec : '0;
      mem_q <= '{ex_q.memread, ex_q.memwrite, ex_q.regwrite, ex_q.memtoreg, ex_q.rd};
      wb_q  <= '{mem_q.regwrite, mem_q.memtoreg, mem_q.rd};
    end
  end
  assign ex_alusrc    = ex_q.alusrc;
  assign ex_memread   = ex_q.memread;
  assign ex_memwrite  = ex_q.memwrite;
  assign ex_regwrite  = ex_q.regwrite;
  assign ex_memtoreg  = ex_q.memtoreg;
  assign ex_aluop     = ex_q.aluop;
  assign ex_br        = ex_q.br;
  assign ex_br_f3     = ex_q.br_f3;
  assign ex_jal       = ex_q.jal;
  assign ex_jalr      = ex_q.jalr;
  assign ex_lui       = ex_q.lui;
  assign ex_auipc     = ex_q.auipc;
  assign ex_mul       = ex_q.mul;
  assign ex_illegal   = ex_q.illegal;
  assign ex_rd        = ex_q.rd;
  assign mem_memread  = mem_q.memread;
  assign mem_memwrite = mem_q.memwrite;
  assign mem_regwrite = mem_q.regwrite;
  assign mem_memtoreg = mem_q.memtoreg;
  assign mem_rd       = mem_q.rd;
  assign wb_regwrite  = wb_q.regwrite;
  assign wb_memtoreg  = wb_q.memtoreg;
  assign wb_rd        = wb_q.rd;
endmodule
